// File: rtl/cam_cfg_seq.sv
// Camera config sequencer: walks the register ROM, hands entries to the SCCB master,
// honours FF_F0 (settle delay) and FF_FF (end). Optional: CAM_CFG_AUTOSTART_EN.
module cam_cfg_seq #(
  parameter int CLK_F    = 24_000_000,
  parameter int DELAY_MS = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_valid,
  input  logic        i_sccb_ready,
  output logic [7:0]  o_sccb_reg,
  output logic [7:0]  o_sccb_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int DELAY_CYCLES = CLK_F / 1000 * DELAY_MS;
  localparam int CNT_W        = $clog2(DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DELAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_DELAY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dly_cnt;
  logic             start_eff;
  logic             last_addr;

`ifdef CAM_CFG_AUTOSTART_EN
  // Set throughout reset, cleared by the first edge after release: one implicit start.
  logic auto_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) auto_pend <= 1'b1;
    else       auto_pend <= 1'b0;
  end

  assign start_eff = i_start | auto_pend;
`else
  assign start_eff = i_start;
`endif

  // The last ROM slot finishes the sequence instead of wrapping back to entry 0.
  assign last_addr = (o_rom_addr == 8'hFF);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_rom_addr   <= '0;
      o_sccb_valid <= 1'b0;
      o_sccb_reg   <= '0;
      o_sccb_data  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      dly_cnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          o_rom_addr <= '0;
          if (start_eff) begin
            o_busy <= 1'b1;
            state  <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          if (i_rom_data == 16'hFFFF) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_DONE;
          end else if (i_rom_data == 16'hFFF0) begin
            dly_cnt <= DLY_LOAD;
            state   <= S_DELAY;
          end else begin
            o_sccb_reg   <= i_rom_data[15:8];
            o_sccb_data  <= i_rom_data[7:0];
            o_sccb_valid <= 1'b1;
            state        <= S_SEND;
          end
        end

        S_SEND: begin
          if (i_sccb_ready) begin
            o_sccb_valid <= 1'b0;
            if (last_addr) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              o_rom_addr <= o_rom_addr + 8'd1;
              state      <= S_FETCH;
            end
          end
        end

        S_DELAY: begin
          if (dly_cnt == '0) begin
            if (last_addr) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              o_rom_addr <= o_rom_addr + 8'd1;
              state      <= S_FETCH;
            end
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end

        S_DONE: begin
          if (start_eff) begin
            o_done     <= 1'b0;
            o_busy     <= 1'b1;
            o_rom_addr <= '0;
            state      <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cam_cfg_seq.md
# cam_cfg_seq

Configuration sequencer that walks the camera register ROM and feeds each `{reg_addr, reg_data}` entry to the SCCB write master. It sits between the synchronous config ROM (one-cycle read latency) and the SCCB master, and interprets the ROM's in-band markers: `16'hFF_F0` inserts a settle delay and `16'hFF_FF` ends the sequence. It reports busy/done to the top-level camera bring-up logic.

## Interface
Parameters:
- `CLK_F`, 24_000_000: `i_clk` frequency in Hz.
- `DELAY_MS`, 10: settle delay in ms for each `FF_F0` marker. `DELAY_CYCLES = CLK_F/1000*DELAY_MS`.

Ports (clock and reset first):
- `i_clk`, in, 1: single clock.
- `i_rst`, in, 1: reset, asynchronous and active-high.
- `i_start`, in, 1: level, sampled in IDLE/DONE; starts or restarts the sequence.
- `o_rom_addr`, out, 8: ROM address.
- `i_rom_data`, in, 16: ROM data; valid one cycle after `o_rom_addr` changes.
- `o_sccb_valid`, out, 1: write request valid.
- `i_sccb_ready`, in, 1: SCCB master can accept a write.
- `o_sccb_reg`, out, 8: register address, `i_rom_data[15:8]`.
- `o_sccb_data`, out, 8: register value, `i_rom_data[7:0]`.
- `o_busy`, out, 1: sequence in progress.
- `o_done`, out, 1: sequence completed; held until restart or reset.

## Operation
- States: IDLE, FETCH, DECODE, SEND, DELAY, DONE.
- IDLE: `o_rom_addr`=0. If `i_start`=1, go to FETCH.
- FETCH: one wait cycle for ROM latency, then go to DECODE.
- DECODE: sample `i_rom_data`.
  - `FFFF` goes to DONE.
  - `FFF0` loads the delay counter with `DELAY_CYCLES-1` and goes to DELAY.
  - Anything else registers reg/data, sets `o_sccb_valid`=1 and goes to SEND.
- SEND: hold `o_sccb_valid`, `o_sccb_reg` and `o_sccb_data` stable until `i_sccb_ready`=1 on a clock edge (transfer accepted).
  - On that edge: `o_sccb_valid`=0, address +1, go to FETCH.
  - `i_sccb_ready` is ignored in every other state.
- DELAY: decrement the counter each cycle. At 0: address +1, go to FETCH. The sequencer spends exactly `DELAY_CYCLES` cycles in DELAY.
- DONE: `o_done`=1, `o_busy`=0. If `i_start`=1: clear `o_done`, address=0, go to FETCH (restart).
- Address wrap: an entry accepted or delayed at address 255 goes to DONE, not back to address 0.
- `i_start` is ignored while `o_busy`=1.
- `o_busy`=1 in FETCH, DECODE, SEND and DELAY.
- Delay counter width is `$clog2(DELAY_CYCLES+1)`.
- `FF_xx` entries other than `F0`/`FF` are sent as ordinary writes (register `0xFF`).

## Timing
- Reset values: state IDLE; `o_rom_addr`=0, `o_sccb_valid`=0, `o_sccb_reg`=0, `o_sccb_data`=0, `o_busy`=0, `o_done`=0; delay counter 0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), including dropping `o_sccb_valid` within the same cycle. After release, the sequencer waits in IDLE for `i_start`.
- Latency, with `i_start` sampled at edge E0:
  - FETCH after E0, DECODE after E1.
  - `o_sccb_valid`=1 after E2, carrying entry 0.
- Per write entry, minimum 3 cycles: FETCH, DECODE, SEND with ready already high.
- Per delay entry: 2 + `DELAY_CYCLES` cycles.
- `FFFF` decoded at edge En gives `o_done`=1 and `o_busy`=0 after En.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `CAM_CFG_AUTOSTART_EN`:
  - Defined: the first cycle after reset release behaves as if `i_start`=1, so the sequence runs once automatically. Later restarts still require `i_start`.
  - Undefined: the sequence starts only on `i_start`.

## Test plan
- Bench ROM model (1-cycle latency) with contents `{12_80, FF_F0, 12_0C, 11_00, FF_FF}`; `CLK_F`=100_000, `DELAY_MS`=10; ready always 1; pulse `i_start` → writes (12,80), then exactly 1000 idle DELAY cycles, then (12,0C), (11,00); `o_done`=1; exactly 3 accepted writes.
- Ready stalls: `i_sccb_ready` low for 7 cycles in SEND → `o_sccb_valid`/reg/data stable all 7 cycles; address advances only after the accepting edge.
- Start while busy: toggle `i_start` during DELAY → no restart and no extra writes. `i_start` in DONE → sequence replays from address 0 and `o_done` clears.
- Reset mid-SEND: assert `i_rst` while valid=1 → `o_sccb_valid`=0 within the same cycle, all outputs reset; rerun completes normally.
- Wrap: ROM with no `FFFF` (all entries `12_34`) → 256 writes, then DONE, no address wrap to 0.
- With `CAM_CFG_AUTOSTART_EN` defined and `i_start` tied 0 → full sequence runs after reset release; without the macro → `o_busy` stays 0.
